// File: rtl/valid_tagged_ram.sv
// valid_tagged_ram: dual-port payload RAM with a per-entry valid bit held in
// flops, a live count of valid entries, and a sweep that clears every valid
// bit after reset or on a flush request. Payload is written only from port A.
// Port B writes only the valid bit and performs the registered reads.
//
// state | meaning
// ------+---------------------------------------------------------------
// SWEEP | clear valid[sweep_addr] each cycle, 0..DEPTH-1; user ports ignored
// IDLE  | normal operation; flush starts a new sweep
module valid_tagged_ram #(
  parameter int    PAYLOAD_BITS  = 32,
  parameter int    NUM_ADDR_BITS = 7,
  parameter string RAM_TYPE      = "block",
  parameter bit    CLEAR_ON_READ = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wea,
  input  logic [NUM_ADDR_BITS-1:0] addra,
  input  logic [PAYLOAD_BITS:0]    dina,
  input  logic                     web,
  input  logic [NUM_ADDR_BITS-1:0] addrb,
  input  logic [PAYLOAD_BITS:0]    dinb,
  input  logic                     rdb,
  output logic [PAYLOAD_BITS:0]    doutb,
  input  logic                     flush,
  output logic                     flush_busy,
  output logic [NUM_ADDR_BITS:0]   vld_count
);

  localparam int DEPTH = 2 ** NUM_ADDR_BITS;
  localparam int CNTW  = NUM_ADDR_BITS + 1;
  // Two extra bits so the +2 / -2 intermediate never wraps before clamping.
  localparam int CW    = NUM_ADDR_BITS + 2;
  localparam logic [NUM_ADDR_BITS-1:0] LAST_ADDR = {NUM_ADDR_BITS{1'b1}};

  typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} state_t;

  state_t                   state, state_next;
  logic [NUM_ADDR_BITS-1:0] sweep_addr, sweep_addr_next;
  logic                     sweep_clr;

  logic [DEPTH-1:0]         valid_q;
  logic [PAYLOAD_BITS-1:0]  mem_rd;

  logic op_en, wr_a, rd_en, same_addr, b_touch, b_val;
  logic a_old, b_old, a_inc, a_dec, b_inc, b_dec;
  logic [CW-1:0]   cnt_up, cnt_dn, cnt_diff;
  logic [CNTW-1:0] cnt_next;

  // Only the valid bit of a port-B write is meaningful.
  logic unused_dinb_payload;
  assign unused_dinb_payload = ^dinb[PAYLOAD_BITS-1:0];

  // State and sweep pointer; reset restarts the sweep from address 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SWEEP;
      sweep_addr <= '0;
    end else begin
      state      <= state_next;
      sweep_addr <= sweep_addr_next;
    end
  end

  // Next state, sweep pointer advance and busy flag.
  always_comb begin
    state_next      = state;
    sweep_addr_next = sweep_addr;
    sweep_clr       = 1'b0;
    flush_busy      = 1'b0;
    case (state)
      SWEEP: begin
        flush_busy      = 1'b1;
        sweep_clr       = 1'b1;
        sweep_addr_next = sweep_addr + 1'b1;
        if (sweep_addr == LAST_ADDR) state_next = IDLE;
      end
      IDLE: begin
        if (flush) begin
          state_next      = SWEEP;
          sweep_addr_next = '0;
        end
      end
      default: state_next = SWEEP;
    endcase
  end

  // Port qualification. Port A owns an address both ports touch, and a
  // clear-on-read never overrides a write to the address being read.
  always_comb begin
    op_en     = (state == IDLE);
    wr_a      = op_en & wea;
    rd_en     = op_en & rdb;
    same_addr = wea & (addra == addrb);
    b_touch   = op_en & (web | (CLEAR_ON_READ & rdb)) & ~same_addr;
    b_val     = web & dinb[PAYLOAD_BITS];
  end

  // Payload storage; the sweep never touches it.
  if (RAM_TYPE == "distributed") begin : g_lut_ram
    (* ram_style = "distributed" *) logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    // Port-A payload write.
    always_ff @(posedge clk) begin
      if (wr_a) mem[addra] <= dina[PAYLOAD_BITS-1:0];
    end
    assign mem_rd = mem[addrb];
  end else begin : g_block_ram
    (* ram_style = "block" *) logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    // Port-A payload write.
    always_ff @(posedge clk) begin
      if (wr_a) mem[addra] <= dina[PAYLOAD_BITS-1:0];
    end
    assign mem_rd = mem[addrb];
  end

  // Valid bits: cleared one per cycle by the sweep, otherwise written by
  // the ports. b_touch never aliases addra, so the two writes are disjoint.
  always_ff @(posedge clk) begin
    if (sweep_clr) begin
      valid_q[sweep_addr] <= 1'b0;
    end else begin
      if (wr_a)    valid_q[addra] <= dina[PAYLOAD_BITS];
      if (b_touch) valid_q[addrb] <= b_val;
    end
  end

  // Registered read, read-first: sees the contents before this edge's writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     doutb <= '0;
    else if (rd_en) doutb <= {valid_q[addrb], mem_rd};
  end

  // Count delta from the 0->1 / 1->0 transitions of the touched addresses,
  // clamped to [0, DEPTH].
  always_comb begin
    a_old    = valid_q[addra];
    b_old    = valid_q[addrb];
    a_inc    = wr_a & dina[PAYLOAD_BITS] & ~a_old;
    a_dec    = wr_a & ~dina[PAYLOAD_BITS] & a_old;
    b_inc    = b_touch & b_val & ~b_old;
    b_dec    = b_touch & ~b_val & b_old;
    cnt_up   = CW'(vld_count) + CW'(a_inc) + CW'(b_inc);
    cnt_dn   = CW'(a_dec) + CW'(b_dec);
    cnt_diff = '0;
    if (cnt_up >= cnt_dn) cnt_diff = cnt_up - cnt_dn;
    if (cnt_diff > CW'(DEPTH)) cnt_diff = CW'(DEPTH);
    cnt_next = CNTW'(cnt_diff);
  end

  // Valid-entry counter; a flush zeroes it on the edge that starts the sweep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               vld_count <= '0;
    else if (op_en && flush)  vld_count <= '0;
    else if (op_en)           vld_count <= cnt_next;
  end

endmodule

// File: tb/tb_valid_tagged_ram.sv
// Directed bench for valid_tagged_ram. Two instances share the stimulus:
// dut0 uses the default read behaviour, dut1 clears the valid bit on read.
module tb_valid_tagged_ram;

  localparam int PB    = 32;
  localparam int AB    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wea = 1'b0, web = 1'b0, rdb = 1'b0, flush = 1'b0;
  logic [AB-1:0] addra = '0, addrb = '0;
  logic [PB:0]   dina = '0, dinb = '0;
  logic [PB:0]   doutb0, doutb1;
  logic          fb0, fb1;
  logic [AB:0]   cnt0, cnt1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  valid_tagged_ram #(.PAYLOAD_BITS(PB), .NUM_ADDR_BITS(AB), .RAM_TYPE("block"),
                     .CLEAR_ON_READ(1'b0)) dut0 (
    .clk(clk), .reset(reset), .wea(wea), .addra(addra), .dina(dina),
    .web(web), .addrb(addrb), .dinb(dinb), .rdb(rdb), .doutb(doutb0),
    .flush(flush), .flush_busy(fb0), .vld_count(cnt0));

  valid_tagged_ram #(.PAYLOAD_BITS(PB), .NUM_ADDR_BITS(AB), .RAM_TYPE("distributed"),
                     .CLEAR_ON_READ(1'b1)) dut1 (
    .clk(clk), .reset(reset), .wea(wea), .addra(addra), .dina(dina),
    .web(web), .addrb(addrb), .dinb(dinb), .rdb(rdb), .doutb(doutb1),
    .flush(flush), .flush_busy(fb1), .vld_count(cnt1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_a(input logic [AB-1:0] a, input logic [PB:0] d);
    wea = 1'b1; addra = a; dina = d;
    tick();
    wea = 1'b0;
  endtask

  task automatic wr_b(input logic [AB-1:0] a, input logic [PB:0] d);
    web = 1'b1; addrb = a; dinb = d;
    tick();
    web = 1'b0;
  endtask

  task automatic rd_b(input logic [AB-1:0] a);
    rdb = 1'b1; addrb = a;
    tick();
    rdb = 1'b0;
  endtask

  // Counts edges until flush_busy falls; optionally hammers the user ports
  // and re-pulses flush partway through to show they are all ignored.
  task automatic wait_sweep(input string tag, input bit drive);
    int n = 0;
    while (fb0 && n < 200) begin
      if (drive) begin
        wea = 1'b1; addra = 7'd9; dina = {1'b1, 32'hDEAD_0009};
        rdb = 1'b1; addrb = 7'd9;
        web = 1'b1; dinb = {1'b1, 32'h0};
        flush = (n >= 50 && n <= 52);
      end
      tick();
      n++;
    end
    wea = 1'b0; rdb = 1'b0; web = 1'b0; flush = 1'b0;
    check({tag, "_len"}, 64'(n), 64'(DEPTH));
    check({tag, "_busy0"}, 64'(fb0), 64'd0);
    check({tag, "_busy1"}, 64'(fb1), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while reset is held, across several edges.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(fb0), 64'd1);
    check("rst_cnt", 64'(cnt0), 64'd0);
    check("rst_dout", 64'(doutb0), 64'd0);
    reset = 1'b1;
    wait_sweep("sweep_rst", 1'b0);

    // Empty after the power-on sweep.
    rd_b(7'd0);
    check("empty_rd0", 64'(doutb0[PB]), 64'd0);
    rd_b(7'd100);
    check("empty_rd100", 64'(doutb0[PB]), 64'd0);
    check("empty_cnt", 64'(cnt0), 64'd0);

    // Write then read.
    wr_a(7'd5, {1'b1, 32'hDEAD_BEEF});
    rd_b(7'd5);
    check("wr5_dout", 64'(doutb0), 64'(33'h1_DEAD_BEEF));
    check("wr5_cnt", 64'(cnt0), 64'd1);

    // Read-first on a same-address collision.
    wr_a(7'd3, {1'b0, 32'h0000_AAAA});
    check("pre3_cnt", 64'(cnt0), 64'd1);
    wea = 1'b1; addra = 7'd3; dina = {1'b1, 32'h1234_5678};
    rdb = 1'b1; addrb = 7'd3;
    tick();
    wea = 1'b0; rdb = 1'b0;
    check("rfw_old", 64'(doutb0), 64'(33'h0_0000_AAAA));
    check("rfw_cnt", 64'(cnt0), 64'd2);
    rd_b(7'd3);
    check("rfw_new", 64'(doutb0), 64'(33'h1_1234_5678));
    tick();
    check("dout_hold", 64'(doutb0), 64'(33'h1_1234_5678));

    // Port A valid wins over port B on the same address.
    wea = 1'b1; addra = 7'd7; dina = {1'b1, 32'h0000_0077};
    web = 1'b1; addrb = 7'd7; dinb = {1'b0, 32'hFFFF_FFFF};
    tick();
    wea = 1'b0; web = 1'b0;
    check("ab7_cnt", 64'(cnt0), 64'd3);
    rd_b(7'd7);
    check("ab7_dout", 64'(doutb0), 64'(33'h1_0000_0077));

    // Port B changes only the valid bit.
    wr_b(7'd5, {1'b0, 32'h0BAD_F00D});
    check("b5clr_cnt", 64'(cnt0), 64'd2);
    rd_b(7'd5);
    check("b5clr_dout", 64'(doutb0), 64'(33'h0_DEAD_BEEF));
    wr_b(7'd5, {1'b1, 32'h0});
    check("b5set_cnt", 64'(cnt0), 64'd3);

    // Rewriting an already-valid entry, then invalidating and restoring it.
    wr_a(7'd3, {1'b1, 32'h1234_5678});
    check("rewr3_cnt", 64'(cnt0), 64'd3);
    wr_a(7'd3, {1'b0, 32'h1234_5678});
    check("inv3_cnt", 64'(cnt0), 64'd2);
    wr_a(7'd3, {1'b1, 32'h1234_5678});
    check("set3_cnt", 64'(cnt0), 64'd3);

    // Both ports on different addresses: +1 and -1 in one edge (valid 3,7,20).
    wea = 1'b1; addra = 7'd20; dina = {1'b1, 32'h20};
    web = 1'b1; addrb = 7'd5; dinb = {1'b0, 32'h0};
    tick();
    wea = 1'b0; web = 1'b0;
    check("dual_cnt", 64'(cnt0), 64'd3);

    // Fill everything; count reaches and holds DEPTH.
    for (int i = 0; i < DEPTH; i++) wr_a(7'(i), {1'b1, 32'(i)});
    check("full_cnt", 64'(cnt0), 64'(DEPTH));
    wr_a(7'd0, {1'b1, 32'd0});
    check("full_sat", 64'(cnt0), 64'(DEPTH));
    rd_b(7'd7);
    check("full_rd7", 64'(doutb0), 64'(33'h1_0000_0007));

    // Flush with port activity and a repeated flush during the sweep.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_cnt", 64'(cnt0), 64'd0);
    check("flush_busy", 64'(fb0), 64'd1);
    wait_sweep("sweep_flush", 1'b1);
    check("sweep_hold", 64'(doutb0), 64'(33'h1_0000_0007));
    check("sweep_cnt", 64'(cnt0), 64'd0);
    rd_b(7'd9);
    check("sweep_rd9", 64'(doutb0), 64'(33'h0_0000_0009));
    check("post_cnt", 64'(cnt0), 64'd0);

    // Clear-on-read behaviour on dut1.
    for (int i = 0; i < 10; i++) wr_a(7'(i), {1'b1, 32'h100 + 32'(i)});
    check("cor_fill", 64'(cnt1), 64'd10);
    rd_b(7'd4);
    check("cor_rd1", 64'(doutb1), 64'(33'h1_0000_0104));
    check("cor_cnt1", 64'(cnt1), 64'd9);
    check("nocor_rd1", 64'(doutb0[PB]), 64'd1);
    rd_b(7'd4);
    check("cor_rd2", 64'(doutb1[PB]), 64'd0);
    check("cor_cnt2", 64'(cnt1), 64'd9);
    check("nocor_rd2", 64'(doutb0[PB]), 64'd1);
    check("nocor_cnt", 64'(cnt0), 64'd10);
    wea = 1'b1; addra = 7'd2; dina = {1'b1, 32'h202};
    rdb = 1'b1; addrb = 7'd2;
    tick();
    wea = 1'b0; rdb = 1'b0;
    check("cor_wr_old", 64'(doutb1), 64'(33'h1_0000_0102));
    check("cor_wr_cnt", 64'(cnt1), 64'd9);
    rd_b(7'd2);
    check("cor_wr_new", 64'(doutb1), 64'(33'h1_0000_0202));
    check("cor_wr_cnt2", 64'(cnt1), 64'd8);

    // Reset mid-operation, then again mid-sweep.
    reset = 1'b0;
    #1;
    check("arst_busy", 64'(fb0), 64'd1);
    check("arst_cnt0", 64'(cnt0), 64'd0);
    check("arst_cnt1", 64'(cnt1), 64'd0);
    check("arst_dout", 64'(doutb0), 64'd0);
    tick();
    reset = 1'b1;
    repeat (40) tick();
    check("mid_busy", 64'(fb0), 64'd1);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    wait_sweep("sweep_restart", 1'b0);
    rd_b(7'd2);
    check("rst_rd2", 64'(doutb0), 64'(33'h0_0000_0202));
    check("rst_cnt_end", 64'(cnt0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/valid_tagged_ram.md
VALID_TAGGED_RAM -- requirements
Module: valid_tagged_ram

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BITS, default 32, data payload width excluding the valid bit.
REQ-002 The block SHALL have parameter NUM_ADDR_BITS, default 7, address width; DEPTH = 2**NUM_ADDR_BITS.
REQ-003 The block SHALL have parameter RAM_TYPE, default "block", storage style of the payload array.
REQ-004 The block SHALL have parameter CLEAR_ON_READ, default 0; when 1, a port-B read clears the valid bit it reads.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have ports wea input 1, addra input NUM_ADDR_BITS, dina input PAYLOAD_BITS+1: port-A write of payload plus valid in the MSB.
REQ-008 The block SHALL have ports web input 1, addrb input NUM_ADDR_BITS, dinb input PAYLOAD_BITS+1: port-B write of the valid bit only (dinb MSB); dinb payload bits are ignored.
REQ-009 The block SHALL have port rdb, input, 1, port-B read enable.
REQ-010 The block SHALL have port doutb, output, PAYLOAD_BITS+1, registered read data, valid in the MSB.
REQ-011 The block SHALL have port flush, input, 1, one-cycle request to clear all valid bits.
REQ-012 The block SHALL have port flush_busy, output, 1, high while a sweep is in progress.
REQ-013 The block SHALL have port vld_count, output, NUM_ADDR_BITS+1, number of entries whose valid bit is 1.

Function
REQ-014 The FSM SHALL have states SWEEP and IDLE.
REQ-015 In SWEEP, the FSM SHALL clear the valid bit at sweep_addr each cycle, counting 0..DEPTH-1, then go to IDLE; a sweep takes exactly DEPTH cycles.
REQ-016 In IDLE, flush=1 SHALL enter SWEEP at sweep_addr 0 and force vld_count to 0 on the next edge; flush is ignored while in SWEEP.
REQ-017 While flush_busy=1, wea, web and rdb SHALL be ignored, and doutb SHALL hold its value.
REQ-018 The payload array SHALL be written from port A only, on wea=1 in IDLE; payload is never cleared by a sweep.
REQ-019 Port-B read latency SHALL be 1 cycle: doutb updates on the edge after rdb=1 and holds otherwise.
REQ-020 Read-during-write to the same address SHALL be read-first: doutb returns the pre-write payload and valid.
REQ-021 On wea and web to the same address, port A's valid bit SHALL win.
REQ-022 With CLEAR_ON_READ=1, rdb SHALL clear valid[addrb] on the same edge unless wea or web targets addrb that cycle, in which case the write wins.
REQ-023 vld_count SHALL update on the same edge as the valid array: +1 for each touched address going 0->1 and -1 for each going 1->0; an address touched by both ports counts once.
REQ-024 vld_count SHALL never wrap: it SHALL saturate at DEPTH and at 0, and reach DEPTH only when every entry is valid.

Reset
REQ-025 Asserting reset SHALL asynchronously set the state to SWEEP, sweep_addr to 0, vld_count to 0, doutb to 0 and flush_busy to 1.
REQ-026 Deasserting reset SHALL start the sweep; flush_busy SHALL fall exactly DEPTH cycles after the first rising edge with reset high.
REQ-027 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from address 0.

Verification
REQ-028 Release reset -> flush_busy=1 for 128 cycles; after that, reading any address gives doutb MSB=0 and vld_count=0.
REQ-029 Write A at addr 5 with payload 0xDEADBEEF and valid=1, then read B at addr 5 -> the next cycle doutb={1,0xDEADBEEF} and vld_count=1.
REQ-030 Write A at addr 3 with valid=1 and read B at addr 3 in the same cycle -> doutb shows the old contents; a read one cycle later shows the new contents.
REQ-031 With CLEAR_ON_READ=1, fill addresses 0..9 and read addr 4 twice -> the first read gives MSB=1, the second gives MSB=0; vld_count goes 10->9.
REQ-032 Write A at addr 7 with valid=1 and write B at addr 7 with valid=0 in the same cycle -> valid[7]=1 and vld_count increments by 1.
REQ-033 Fill all 128 entries (vld_count=128), pulse flush, and drive wea during the sweep -> vld_count=0, the writes are ignored, and flush_busy drops after 128 cycles.
